// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit: funct3 encodings,
// the read-modify-write FSM states and the data memory geometry.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_ADDR_W = 6;
  localparam int MEM_BYTES  = 1 << (LSU_ADDR_W + 2);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MERGE_WR = 1'b1
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load byte/half extraction with extension,
// and sub-word lane merge of store data into a previously read word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_off,
  input  logic [31:0] load_word,
  output logic [31:0] load_data,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_word,
  input  logic [31:0] st_data,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = load_word[7:0];
    case (load_off)
      2'd0: sel_byte = load_word[7:0];
      2'd1: sel_byte = load_word[15:8];
      2'd2: sel_byte = load_word[23:16];
      2'd3: sel_byte = load_word[31:24];
      default: sel_byte = load_word[7:0];
    endcase
    sel_half = load_off[1] ? load_word[31:16] : load_word[15:0];

    case (load_funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = load_word;
    endcase
  end

  // Only SB and SH ever reach the merge path; anything other than B is a half.
  always_comb begin
    merged = st_word;
    if (st_funct3 == F3_B) begin
      case (st_off)
        2'd0: merged[7:0]   = st_data[7:0];
        2'd1: merged[15:8]  = st_data[7:0];
        2'd2: merged[23:16] = st_data[7:0];
        2'd3: merged[31:24] = st_data[7:0];
        default: merged = st_word;
      endcase
    end else if (st_off[1]) begin
      merged[31:16] = st_data[15:0];
    end else begin
      merged[15:0] = st_data[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed core requests onto a word-wide memory,
// with a two-cycle read-modify-write for SB/SH and trapping of bad requests.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              fault,
  output logic [31:0]       fault_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_e            dbg_state
);

  // Handshake: a request is presented with req_valid=1 and is accepted at a
  // rising edge where stall=0; while stall=1 the core holds req_* unchanged.

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] word;
  logic [1:0]        off;
  logic              f3_load_ok, f3_store_ok, misaligned, out_of_range, illegal;
  logic              start_rmw, take_fault;
  logic [ADDR_W-1:0] cap_word;
  logic [1:0]        cap_off;
  logic [31:0]       cap_rdata, cap_wdata;
  logic [2:0]        cap_funct3;
  logic [31:0]       load_data, merged;

  assign word      = req_addr[ADDR_W+1:2];
  assign off       = req_addr[1:0];
  assign dbg_state = state;

  always_comb begin
    f3_load_ok   = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    f3_store_ok  = req_funct3 inside {F3_B, F3_H, F3_W};
    misaligned   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && off[0]) ||
                   ((req_funct3 == F3_W) && (off != 2'b00));
    out_of_range = |req_addr[31:ADDR_W+2];
    illegal      = misaligned || out_of_range || (req_we ? !f3_store_ok : !f3_load_ok);
    take_fault   = (state == IDLE) && req_valid && illegal;
    start_rmw    = (state == IDLE) && req_valid && !illegal && req_we &&
                   (req_funct3 != F3_W);
  end

  lsu_align u_align (
    .load_funct3 (req_funct3),
    .load_off    (off),
    .load_word   (mem_rdata),
    .load_data   (load_data),
    .st_funct3   (cap_funct3),
    .st_off      (cap_off),
    .st_word     (cap_rdata),
    .st_data     (cap_wdata),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_rmw) state_nxt = MERGE_WR;
      MERGE_WR: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    stall     = 1'b0;
    mem_addr  = word;
    mem_wdata = req_wdata;
    rdata     = '0;
    case (state)
      IDLE: begin
        if (req_valid && !illegal) begin
          if (!req_we) begin
            mem_read = 1'b1;
            rdata    = load_data;
          end else if (req_funct3 == F3_W) begin
            mem_write = 1'b1;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
          end
        end
      end
      MERGE_WR: begin
        mem_write = 1'b1;
        mem_addr  = cap_word;
        mem_wdata = merged;
      end
      default: ;
    endcase
    // Strobes must never fire into memory while reset is held.
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_word   <= '0;
      cap_off    <= '0;
      cap_rdata  <= '0;
      cap_wdata  <= '0;
      cap_funct3 <= '0;
    end else if (start_rmw) begin
      cap_word   <= word;
      cap_off    <= off;
      cap_rdata  <= mem_rdata;
      cap_wdata  <= req_wdata;
      cap_funct3 <= req_funct3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      fault <= take_fault;
      if (take_fault) fault_addr <= req_addr;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64x32 data memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rdata;
  logic        stall, fault;
  logic [31:0] fault_addr;
  logic        mem_read, mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  state_e      dbg_state;

  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [64];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .stall(stall), .fault(fault), .fault_addr(fault_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (pre_we)         mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        valid;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_read;
    logic        exp_write;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [20];
  int   nvec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic cr,
                     input logic [31:0] er, input logic rd, input logic wr, input logic fl);
    vecs[nvec] = '{v, we, f3, a, wd, cr, er, rd, wr, fl};
    nvec++;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic apply(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(t.valid, t.we, t.f3, t.addr, t.wdata);
    #1;
    if (t.chk_rdata) chk({tag, ".rdata"}, rdata, t.exp_rdata);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".mem_read"}, 32'(mem_read), 32'(t.exp_read));
    chk({tag, ".mem_write"}, 32'(mem_write), 32'(t.exp_write));
    if (t.exp_read || t.exp_write) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(t.addr[7:2]));
    if (t.exp_write) chk({tag, ".mem_wdata"}, mem_wdata, t.wdata);
    @(posedge clk);
    #1;
    chk({tag, ".fault"}, 32'(fault), 32'(t.exp_fault));
    if (t.exp_fault) chk({tag, ".fault_addr"}, fault_addr, t.addr);
  endtask

  initial begin
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, F3_W, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.fault_addr", fault_addr, 32'd0);
    chk("rst.mem_read", 32'(mem_read), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'(IDLE));
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    preload(6'd0, 32'h6701ACE6);
    preload(6'd1, 32'h59522359);
    preload(6'd2, 32'h14218670);

    add(1, 0, F3_B,  32'h000, 32'h0,        1, 32'hFFFFFFE6, 1, 0, 0);
    add(1, 0, F3_BU, 32'h001, 32'h0,        1, 32'h000000AC, 1, 0, 0);
    add(1, 0, F3_H,  32'h002, 32'h0,        1, 32'h00006701, 1, 0, 0);
    add(1, 0, F3_B,  32'h001, 32'h0,        1, 32'hFFFFFFAC, 1, 0, 0);
    add(1, 0, F3_HU, 32'h000, 32'h0,        1, 32'h0000ACE6, 1, 0, 0);
    add(1, 0, F3_H,  32'h000, 32'h0,        1, 32'hFFFFACE6, 1, 0, 0);
    add(1, 0, F3_BU, 32'h003, 32'h0,        1, 32'h00000067, 1, 0, 0);
    add(1, 0, F3_W,  32'h008, 32'h0,        1, 32'h14218670, 1, 0, 0);
    add(0, 0, F3_W,  32'h000, 32'h0,        1, 32'h00000000, 0, 0, 0);
    add(1, 1, F3_W,  32'h00C, 32'hDEADBEEF, 0, 32'h0,        0, 1, 0);
    add(1, 0, F3_W,  32'h00C, 32'h0,        1, 32'hDEADBEEF, 1, 0, 0);
    add(1, 1, F3_W,  32'h0FC, 32'h80112233, 0, 32'h0,        0, 1, 0);
    add(1, 0, F3_B,  32'h0FF, 32'h0,        1, 32'hFFFFFF80, 1, 0, 0);
    add(1, 0, F3_H,  32'h003, 32'h0,        1, 32'h00000000, 0, 0, 1);
    add(1, 0, F3_W,  32'h200, 32'h0,        1, 32'h00000000, 0, 0, 1);
    add(1, 1, 3'b100, 32'h000, 32'h0,       0, 32'h0,        0, 0, 1);
    add(1, 0, 3'b011, 32'h000, 32'h0,       1, 32'h00000000, 0, 0, 1);

    for (int i = 0; i < nvec; i++) apply(vecs[i], i);

    // SB into word1 lane 1, then read back the merged word.
    @(negedge clk);
    drive(1'b1, 1'b1, F3_B, 32'h5, 32'h000000AA);
    #1;
    chk("sb.c1.stall", 32'(stall), 32'd1);
    chk("sb.c1.mem_read", 32'(mem_read), 32'd1);
    chk("sb.c1.mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    #1;
    chk("sb.c2.mem_write", 32'(mem_write), 32'd1);
    chk("sb.c2.mem_addr", 32'(mem_addr), 32'd1);
    chk("sb.c2.mem_wdata", mem_wdata, 32'h5952AA59);
    chk("sb.c2.stall", 32'(stall), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, F3_W, 32'h4, 32'h0);
    #1;
    chk("sb.lw.rdata", rdata, 32'h5952AA59);

    // SH into the upper half of word2.
    @(negedge clk);
    drive(1'b1, 1'b1, F3_H, 32'hA, 32'h00001234);
    #1;
    chk("sh.c1.stall", 32'(stall), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    #1;
    chk("sh.c2.mem_write", 32'(mem_write), 32'd1);
    chk("sh.c2.mem_wdata", mem_wdata, 32'h12348670);

    // Misaligned LW: fault pulses for exactly one cycle.
    @(negedge clk);
    drive(1'b1, 1'b0, F3_W, 32'h6, 32'h0);
    #1;
    chk("lw6.mem_read", 32'(mem_read), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    #1;
    chk("lw6.fault", 32'(fault), 32'd1);
    chk("lw6.fault_addr", fault_addr, 32'h6);
    @(negedge clk);
    #1;
    chk("lw6.fault_end", 32'(fault), 32'd0);

    // Out-of-range SW.
    @(negedge clk);
    drive(1'b1, 1'b1, F3_W, 32'h100, 32'hCAFEF00D);
    #1;
    chk("sw100.mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    #1;
    chk("sw100.fault", 32'(fault), 32'd1);
    chk("sw100.fault_addr", fault_addr, 32'h100);
    @(negedge clk);
    #1;
    chk("sw100.fault_end", 32'(fault), 32'd0);

    // Reset asserted in MERGE_WR drops the pending write.
    @(negedge clk);
    drive(1'b1, 1'b1, F3_B, 32'h0, 32'h00000055);
    @(posedge clk);
    #1;
    chk("rmwrst.pre_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmwrst.mem_write", 32'(mem_write), 32'd0);
    chk("rmwrst.stall", 32'(stall), 32'd0);
    chk("rmwrst.state", 32'(dbg_state), 32'(IDLE));
    chk("rmwrst.fault_addr", fault_addr, 32'd0);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmwrst.word0", mem[0], 32'h6701ACE6);
    drive(1'b1, 1'b0, F3_W, 32'h0, 32'h0);
    #1;
    chk("rmwrst.lw0", rdata, 32'h6701ACE6);
    chk("rmwrst.lw0_stall", 32'(stall), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
